// File: rtl/cam_lane_aligner.sv
// cam_lane_aligner: per-camera LVDS word aligner; bitslips each lane until it shows TRAIN_PATTERN, then forwards data.
// Ports: c/rst_n clock and async active-low reset; start (re)train pulse; pll_locked deserializer lock;
// rxd raw lane words in, rxd_out polarity-corrected registered words out; bitslip per-lane slip pulses;
// data_valid/aligned high in LOCKED; fail training ended with a failed lane; lane_ok/lane_fail/slip_cnt per-lane status.
module cam_lane_aligner #(
    parameter int               LANES         = 5,
    parameter int               DESER         = 8,
    parameter logic [DESER-1:0] TRAIN_PATTERN = 8'h3A,
    parameter logic [LANES-1:0] INVERT_MASK   = '0,
    parameter int               SETTLE_CYC    = 64,
    parameter int               SLIP_WAIT     = 4,
    parameter int               MATCH_CNT     = 16,
    parameter int               MAX_SLIPS     = 2*DESER,
    localparam int              SCW           = $clog2(MAX_SLIPS+1)
) (
    input  logic                   c,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pll_locked,
    input  logic [LANES*DESER-1:0] rxd,
    output logic [LANES-1:0]       bitslip,
    output logic [LANES*DESER-1:0] rxd_out,
    output logic                   data_valid,
    output logic                   aligned,
    output logic                   fail,
    output logic [LANES-1:0]       lane_ok,
    output logic [LANES-1:0]       lane_fail,
    output logic [LANES*SCW-1:0]   slip_cnt
);
    localparam int MW  = $clog2(MATCH_CNT+1);
    localparam int WW  = $clog2(SLIP_WAIT+2);
    localparam int STW = $clog2(SETTLE_CYC+1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_TRAIN, S_LOCKED, S_FAIL} state_t;

    state_t                 state_q, state_d;
    logic [STW-1:0]         settle_q, settle_d;
    logic [LANES*DESER-1:0] w_q, w_d;
    logic [MW-1:0]          match_q [LANES];
    logic [MW-1:0]          match_d [LANES];
    logic [SCW-1:0]         slip_q [LANES];
    logic [SCW-1:0]         slip_d [LANES];
    logic [WW-1:0]          wait_q [LANES];
    logic [WW-1:0]          wait_d [LANES];
    logic [LANES-1:0]       bitslip_q, bitslip_d;
    logic [LANES-1:0]       ok_q, ok_d;
    logic [LANES-1:0]       lfail_q, lfail_d;
    logic                   aligned_q, aligned_d;
    logic                   fail_q, fail_d;

    always_comb begin
        w_d = rxd;
        for (int i = 0; i < LANES; i++)
            w_d[i*DESER +: DESER] = rxd[i*DESER +: DESER] ^ {DESER{INVERT_MASK[i]}};
        state_d   = state_q;
        settle_d  = settle_q;
        match_d   = match_q;
        slip_d    = slip_q;
        wait_d    = wait_q;
        bitslip_d = '0;
        ok_d      = ok_q;
        lfail_d   = lfail_q;
        if (state_q != S_IDLE && !pll_locked) begin
            // status flags and slip counts are kept for debug after losing lock
            state_d = S_IDLE;
            for (int i = 0; i < LANES; i++) begin
                match_d[i] = '0;
                wait_d[i]  = '0;
            end
        end else if (start && pll_locked) begin
            state_d  = S_SETTLE;
            settle_d = '0;
            ok_d     = '0;
            lfail_d  = '0;
            for (int i = 0; i < LANES; i++) begin
                match_d[i] = '0;
                slip_d[i]  = '0;
                wait_d[i]  = '0;
            end
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (settle_q == STW'(SETTLE_CYC-1)) state_d = S_TRAIN;
                    else settle_d = settle_q + 1'b1;
                end
                S_TRAIN: begin
                    if (&ok_q) state_d = S_LOCKED;
                    else if (&(ok_q | lfail_q)) state_d = S_FAIL;
                    for (int i = 0; i < LANES; i++) begin
                        if (!ok_q[i] && !lfail_q[i]) begin
                            // wait covers the pulse cycle plus SLIP_WAIT quiet cycles
                            if (wait_q[i] != '0) begin
                                wait_d[i] = wait_q[i] - 1'b1;
                            end else if (w_q[i*DESER +: DESER] == TRAIN_PATTERN) begin
                                match_d[i] = match_q[i] + 1'b1;
                                if (match_q[i] == MW'(MATCH_CNT-1)) ok_d[i] = 1'b1;
                            end else if (slip_q[i] == SCW'(MAX_SLIPS)) begin
                                lfail_d[i] = 1'b1;
                            end else begin
                                match_d[i]   = '0;
                                bitslip_d[i] = 1'b1;
                                slip_d[i]    = slip_q[i] + 1'b1;
                                wait_d[i]    = WW'(SLIP_WAIT+1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        aligned_d = state_d == S_LOCKED;
        fail_d    = state_d == S_FAIL;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            w_q       <= '0;
            match_q   <= '{default: '0};
            slip_q    <= '{default: '0};
            wait_q    <= '{default: '0};
            bitslip_q <= '0;
            ok_q      <= '0;
            lfail_q   <= '0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            w_q       <= w_d;
            match_q   <= match_d;
            slip_q    <= slip_d;
            wait_q    <= wait_d;
            bitslip_q <= bitslip_d;
            ok_q      <= ok_d;
            lfail_q   <= lfail_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        slip_cnt = '0;
        for (int i = 0; i < LANES; i++) slip_cnt[i*SCW +: SCW] = slip_q[i];
    end

    assign bitslip    = bitslip_q;
    assign rxd_out    = w_q;
    assign aligned    = aligned_q;
    assign data_valid = aligned_q;
    assign fail       = fail_q;
    assign lane_ok    = ok_q;
    assign lane_fail  = lfail_q;
endmodule

// File: tb/tb_cam_lane_aligner.sv
// tb_cam_lane_aligner: directed bench for cam_lane_aligner with a rotating-lane deserializer model.
module tb_cam_lane_aligner;
    localparam int L  = 5;
    localparam int D  = 8;
    localparam int SW = 5;

    logic              c, rst_n, start, pll_locked;
    logic [L*D-1:0]    rxd, rxd_out;
    logic [L-1:0]      bitslip, lane_ok, lane_fail;
    logic              data_valid, aligned, fail;
    logic [L*SW-1:0]   slip_cnt;

    cam_lane_aligner #(.INVERT_MASK(5'b00001)) dut (
        .c(c), .rst_n(rst_n), .start(start), .pll_locked(pll_locked), .rxd(rxd),
        .bitslip(bitslip), .rxd_out(rxd_out), .data_valid(data_valid), .aligned(aligned),
        .fail(fail), .lane_ok(lane_ok), .lane_fail(lane_fail), .slip_cnt(slip_cnt)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    logic [L-1:0][2:0] ph, init_ph;
    logic              load;
    logic [L-1:0]      cmask;
    logic [L-1:0][7:0] cor;

    function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] k);
        logic [7:0] r;
        r = x;
        for (int j = 0; j < int'(k); j++) r = {r[6:0], r[7]};
        return r;
    endfunction

    always @(posedge c)
        for (int i = 0; i < L; i++)
            if (load) ph[i] <= init_ph[i];
            else if (bitslip[i]) ph[i] <= ph[i] - 3'd1;

    always_comb begin
        rxd = '0;
        for (int i = 0; i < L; i++)
            rxd[i*D +: D] = cmask[i] ? 8'h00 : rotl(8'h3A, ph[i]) ^ (i == 0 ? 8'hFF : 8'h00) ^ cor[i];
    end

    int pulses [L] = '{default: 0};
    int last   [L] = '{default: -100};
    int sp_err = 0;
    int cyc    = 0;

    always begin
        @(posedge c);
        #2;
        cyc++;
        if (start) begin
            sp_err = 0;
            for (int i = 0; i < L; i++) begin
                pulses[i] = 0;
                last[i]   = -100;
            end
        end else begin
            for (int i = 0; i < L; i++)
                if (bitslip[i]) begin
                    pulses[i]++;
                    if (cyc - last[i] < 5) sp_err++;
                    last[i] = cyc;
                end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic kick(input logic [L-1:0][2:0] offs);
        @(negedge c);
        init_ph = offs;
        load    = 1'b1;
        start   = 1'b1;
        @(negedge c);
        load    = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit done;
        done = 1'b0;
        for (int k = 0; k < lim && !done; k++) begin
            @(negedge c);
            done = aligned || fail;
        end
        if (!done) chk("done_timeout", {62'd0, aligned, fail}, 64'd1);
    endtask

    typedef struct {
        logic [L-1:0][2:0] off;
        logic [L-1:0]      cm;
        logic [L-1:0][4:0] slip;
        logic              al;
        logic              fl;
        logic [L-1:0]      ok;
        logic [L-1:0]      lf;
        int                p2;
    } vec_t;

    vec_t vecs [4];
    logic [L-1:0][4:0] e;
    logic [L-1:0][2:0] offs_a;

    initial begin
        vecs[0] = '{off: {3'd2,3'd7,3'd3,3'd1,3'd0}, cm: 5'b00000, slip: {5'd2,5'd7,5'd3,5'd1,5'd0},
                    al: 1'b1, fl: 1'b0, ok: 5'b11111, lf: 5'b00000, p2: 3};
        vecs[1] = '{off: '0, cm: 5'b00000, slip: '0,
                    al: 1'b1, fl: 1'b0, ok: 5'b11111, lf: 5'b00000, p2: 0};
        vecs[2] = '{off: {3'd2,3'd7,3'd3,3'd1,3'd0}, cm: 5'b00100, slip: {5'd2,5'd7,5'd16,5'd1,5'd0},
                    al: 1'b0, fl: 1'b1, ok: 5'b11011, lf: 5'b00100, p2: 16};
        vecs[3] = '{off: {3'd7,3'd7,3'd7,3'd7,3'd7}, cm: 5'b00000, slip: {5'd7,5'd7,5'd7,5'd7,5'd7},
                    al: 1'b1, fl: 1'b0, ok: 5'b11111, lf: 5'b00000, p2: 7};
        offs_a = {3'd2,3'd7,3'd3,3'd1,3'd0};

        rst_n = 1'b0; start = 1'b0; pll_locked = 1'b1; load = 1'b0;
        cmask = '0; cor = '0; init_ph = '0;
        repeat (3) @(negedge c);
        chk("rst_aligned", aligned, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_fail", fail, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_lane_ok", lane_ok, 0);
        chk("rst_lane_fail", lane_fail, 0);
        chk("rst_slip_cnt", slip_cnt, 0);
        chk("rst_rxd_out", rxd_out, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge c);
        chk("idle_aligned", aligned, 0);

        for (int v = 0; v < 4; v++) begin
            cmask = vecs[v].cm;
            kick(vecs[v].off);
            wait_done(1000);
            chk($sformatf("v%0d_aligned", v), aligned, vecs[v].al);
            chk($sformatf("v%0d_valid", v), data_valid, vecs[v].al);
            chk($sformatf("v%0d_fail", v), fail, vecs[v].fl);
            chk($sformatf("v%0d_lane_ok", v), lane_ok, vecs[v].ok);
            chk($sformatf("v%0d_lane_fail", v), lane_fail, vecs[v].lf);
            chk($sformatf("v%0d_slip_cnt", v), slip_cnt, vecs[v].slip);
            chk($sformatf("v%0d_pulses2", v), pulses[2], vecs[v].p2);
            chk($sformatf("v%0d_spacing", v), sp_err, 0);
        end
        cmask = '0;

        chk("lag_before", rxd_out[7:0], 8'h3A);
        cor[0] = 8'hFF;
        #1 chk("lag_same_cycle", rxd_out[7:0], 8'h3A);
        @(negedge c);
        chk("lag_next_cycle", rxd_out[7:0], 8'hC5);
        cor[0] = 8'h00;
        @(negedge c);
        chk("lag_restore", rxd_out[7:0], 8'h3A);

        kick(offs_a);
        chk("restart_aligned", aligned, 0);
        chk("restart_valid", data_valid, 0);
        chk("restart_slip_clr", slip_cnt, 0);
        chk("restart_ok_clr", lane_ok, 0);
        repeat (62) @(negedge c);
        chk("settle_aligned", aligned, 0);
        chk("settle_no_slip", slip_cnt, 0);
        wait_done(1000);
        chk("relock_aligned", aligned, 1);
        chk("relock_slip_cnt", slip_cnt, {5'd2,5'd7,5'd3,5'd1,5'd0});

        kick('0);
        repeat (72) @(negedge c);
        cor[1] = 8'h01;
        @(negedge c);
        cor[1] = 8'h00;
        wait_done(1000);
        e = '0;
        e[1] = 5'd8;
        chk("corrupt_aligned", aligned, 1);
        chk("corrupt_slip_cnt", slip_cnt, e);
        chk("corrupt_pulses1", pulses[1], 8);
        chk("corrupt_lane_ok", lane_ok, 5'b11111);

        kick({3'd0,3'd0,3'd0,3'd7,3'd0});
        for (int k = 0; k < 500 && slip_cnt[SW +: SW] != 5'd3; k++) @(negedge c);
        chk("drop_slip3_reached", slip_cnt[SW +: SW], 3);
        pll_locked = 1'b0;
        @(negedge c);
        chk("drop_bitslip", bitslip, 0);
        chk("drop_aligned", aligned, 0);
        chk("drop_slip_hold", slip_cnt[SW +: SW], 3);
        repeat (3) @(negedge c);
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        repeat (8) @(negedge c);
        chk("nolock_start_ignored", slip_cnt[SW +: SW], 3);
        chk("nolock_bitslip", bitslip, 0);
        pll_locked = 1'b1;
        kick('0);
        chk("drop_restart_clr", slip_cnt, 0);
        chk("drop_restart_ok", lane_ok, 0);
        wait_done(1000);
        chk("drop_relock", aligned, 1);

        kick({3'd0,3'd0,3'd0,3'd7,3'd0});
        for (int k = 0; k < 500 && bitslip == '0; k++) begin
            @(posedge c);
            #1;
        end
        chk("ares_slip_seen", |bitslip, 1);
        rst_n = 1'b0;
        #1;
        chk("ares_bitslip", bitslip, 0);
        chk("ares_slip_cnt", slip_cnt, 0);
        chk("ares_aligned", aligned, 0);
        @(negedge c);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cam_lane_aligner.md
Name: cam_lane_aligner

Overview:
Automatic word-alignment controller for one camera's LVDS deserializer. It replaces the tied-off bitslip inputs with trained alignment. It sits between the cam_lvds_rx instance (one per camera) and top, in the rx_coreclock domain. It issues per-lane bitslip pulses until every lane shows the sensor training word, then forwards polarity-corrected data. Lane count, deserialization factor, pattern and per-lane polarity are all parameters.

Parameters:
LANES, 5, lanes per camera (data lanes plus sync lane).
DESER, 8, deserialization factor, i.e. bits per lane word.
TRAIN_PATTERN, 8'h3A, expected per-lane training word, DESER bits wide, compared after polarity correction.
INVERT_MASK, 0, LANES-bit mask; 1 inverts that lane's word (PCB polarity swap).
SETTLE_CYC, 64, cycles to wait after pll_locked before training starts.
SLIP_WAIT, 4, cycles a lane waits after a bitslip pulse before comparing again.
MATCH_CNT, 16, consecutive matches a lane needs to be marked ok.
MAX_SLIPS, 2*DESER, slips without reaching ok before a lane is marked failed.

Ports:
c  in  1  rx_coreclock of this camera; the only clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: (re)train; from pio_output via synchronizer.
pll_locked  in  1  deserializer PLL lock.
rxd  in  LANES*DESER  raw deserializer words; lane i = rxd[i*DESER +: DESER].
bitslip  out  LANES  one-cycle-wide bitslip pulses to rx_bitslip_ctrl.
rxd_out  out  LANES*DESER  polarity-corrected, registered data.
data_valid  out  1  high while in LOCKED.
aligned  out  1  all lanes ok (state LOCKED).
fail  out  1  training ended with at least one failed lane.
lane_ok  out  LANES  per-lane ok flags.
lane_fail  out  LANES  per-lane failed flags.
slip_cnt  out  LANES*SCW  per-lane slips issued; SCW = $clog2(MAX_SLIPS+1).

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Input stage: w_i = rxd lane i XOR {DESER{INVERT_MASK[i]}}, registered once. All comparisons use the registered w_i. rxd_out equals registered w_i, so it lags rxd by 1 cycle in every state.
- FSM states: IDLE, SETTLE, TRAIN, LOCKED, FAIL.
- IDLE: on start=1 and pll_locked=1, go to SETTLE, clear the settle counter, and clear lane_ok, lane_fail and slip_cnt. If start=1 and pll_locked=0, the pulse is ignored.
- SETTLE: count SETTLE_CYC cycles, then go to TRAIN.
- Per lane in TRAIN, each lane is independent and all lanes run in parallel:
  - match: if w_i==TRAIN_PATTERN, increment match_i.
  - ok: when match_i reaches MATCH_CNT, set lane_ok[i]; the lane stops acting.
  - mismatch with slip_cnt_i < MAX_SLIPS: clear match_i. On the next cycle pulse bitslip[i] for exactly 1 cycle and increment slip_cnt_i. Then ignore the lane for SLIP_WAIT cycles before comparing again.
  - mismatch with slip_cnt_i == MAX_SLIPS: set lane_fail[i]; no further slips on that lane.
  - bitslip[i] is never asserted on two consecutive cycles.
- TRAIN exit: all lane_ok set -> LOCKED. All lanes ok-or-failed with at least one failed -> FAIL, fail=1.
- LOCKED: aligned=1, data_valid=1. No monitoring of data content; bitslip stays 0.
- Any state except IDLE: pll_locked=0 -> IDLE in 1 cycle. This clears aligned, data_valid, fail and match counters and suppresses any pending bitslip. lane_ok, lane_fail and slip_cnt hold their values for debug.
- start=1 in SETTLE, TRAIN, LOCKED or FAIL (pll_locked=1): restart at SETTLE with all per-lane state cleared. start has priority over the same-cycle TRAIN exit.
- Async reset mid-training: bitslip drops immediately; no partial pulse.
- slip_cnt saturates at MAX_SLIPS and never wraps.

Test Plan:
- Bench model rotates each lane's word by one bit per bitslip. Initial offsets {0,1,3,7,2}, TRAIN_PATTERN=8'h3A, pll_locked=1, start pulse -> after SETTLE, slip_cnt={0,1,3,7,2}, aligned=1, data_valid=1, lane_fail=0.
- INVERT_MASK=5'b00001; lane 0 driven with ~8'h3A at offset 0 -> zero slips on lane 0, aligned=1, rxd_out lane 0 = 8'h3A one cycle after rxd.
- Lane 2 driven constant 8'h00 -> lane 2 gets exactly 16 bitslip pulses, each separated by at least SLIP_WAIT+1 cycles. Then lane_fail=5'b00100, fail=1, aligned=0.
- pll_locked dropped mid-TRAIN after 3 slips on lane 1 -> next cycle IDLE, bitslip=0, slip_cnt lane 1 stays 3. A new start with pll_locked=1 clears it to 0.
- start pulsed while LOCKED -> aligned falls the next cycle, SETTLE runs 64 cycles, retrains, re-locks with slip_cnt recounted from 0.
- A single corrupted word at match 10 on a lane at the correct offset -> match restarts, one bitslip issued, alignment eventually re-achieved after a full rotation (slip_cnt = DESER).
